max_args_ctrl: RTL and testbench

- Slave-side sequencer for the max_args search interface: drives reset_max, Ntau and Nf, then waits for done_max from the max-search block.
- Sits between the acquisition control registers and the max-search block.
- Latches a search configuration on start, clears the max-search state, and supervises the run with a cycle counter and timeout.
- Reports completion, timeout and configuration errors as a status word and a one-cycle interrupt pulse.

---
 rtl/max_args_ctrl_if.sv | 12 +
 rtl/max_args_ctrl.sv | 145 ++++++++++++++
 tb/tb_max_args_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/max_args_ctrl_if.sv
// Handshake bundle between the search sequencer and the max-search block.
// The sequencer side (slave) drives the clear strobe and search dimensions
// and watches for the completion flag.
interface max_args_interface;
   logic        reset_max;
   logic [15:0] Ntau;
   logic [15:0] Nf;
   logic        done_max;

   modport slave  (output reset_max, output Ntau, output Nf, input done_max);
   modport master (input reset_max, input Ntau, input Nf, output done_max);
endinterface

// File: rtl/max_args_ctrl.sv
// Search sequencer for the max-search block. It latches a configuration on
// start, holds the search block cleared for RESET_LEN cycles, then supervises
// the run with a saturating cycle counter and an optional timeout. Outcome is
// reported through sticky status flags and a one-cycle irq pulse.
module max_args_ctrl #(
   parameter int unsigned RESET_LEN = 4,
   parameter int unsigned CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 abort,
   input  logic [15:0]          cfg_ntau,
   input  logic [15:0]          cfg_nf,
   input  logic [CNT_W-1:0]     cfg_timeout,
   max_args_interface.slave     max_args,
   output logic                 busy,
   output logic                 irq,
   output logic [2:0]           status,
   output logic [CNT_W-1:0]     run_cycles
);

   localparam int unsigned CLR_W = (RESET_LEN > 1) ? $clog2(RESET_LEN) : 1;
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(RESET_LEN - 1);

   // status bit positions: {cfg_err, timeout, done}
   localparam int ST_DONE = 0;
   localparam int ST_TOUT = 1;
   localparam int ST_CERR = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t             state_q,      state_d;
   logic [CLR_W-1:0]   clr_cnt_q,    clr_cnt_d;
   logic [15:0]        ntau_q,       ntau_d;
   logic [15:0]        nf_q,         nf_d;
   logic [CNT_W-1:0]   timeout_q,    timeout_d;
   logic [CNT_W-1:0]   run_cycles_q, run_cycles_d;
   logic [2:0]         status_q,     status_d;
   logic               irq_q,        irq_d;

   logic               tout_hit;

   // The timeout fires on the last permitted RUN cycle so that RUN lasts
   // exactly timeout cycles; a zero timeout disables the check entirely.
   assign tout_hit = (timeout_q != '0) && (run_cycles_q == timeout_q - CNT_W'(1));

   // Next-state and datapath decode; abort beats done, done beats timeout.
   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      ntau_d       = ntau_q;
      nf_d         = nf_q;
      timeout_d    = timeout_q;
      run_cycles_d = run_cycles_q;
      status_d     = status_q;
      irq_d        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               status_d = '0;
               ntau_d   = cfg_ntau;
               nf_d     = cfg_nf;
               if ((cfg_ntau == '0) || (cfg_nf == '0)) begin
                  status_d[ST_CERR] = 1'b1;
                  irq_d             = 1'b1;
               end else begin
                  timeout_d    = cfg_timeout;
                  run_cycles_d = '0;
                  clr_cnt_d    = '0;
                  state_d      = S_CLEAR;
               end
            end
         end

         S_CLEAR: begin
            if (abort) begin
               state_d = S_IDLE;
               irq_d   = 1'b1;
            end else if (clr_cnt_q == CLR_LAST) begin
               state_d = S_RUN;
            end else begin
               clr_cnt_d = clr_cnt_q + CLR_W'(1);
            end
         end

         S_RUN: begin
            if (run_cycles_q != '1)
               run_cycles_d = run_cycles_q + CNT_W'(1);
            if (abort) begin
               state_d = S_IDLE;
               irq_d   = 1'b1;
            end else if (max_args.done_max) begin
               status_d[ST_DONE] = 1'b1;
               state_d           = S_IDLE;
               irq_d             = 1'b1;
            end else if (tout_hit) begin
               status_d[ST_TOUT] = 1'b1;
               state_d           = S_IDLE;
               irq_d             = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, all async-cleared.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         clr_cnt_q    <= '0;
         ntau_q       <= '0;
         nf_q         <= '0;
         timeout_q    <= '0;
         run_cycles_q <= '0;
         status_q     <= '0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         ntau_q       <= ntau_d;
         nf_q         <= nf_d;
         timeout_q    <= timeout_d;
         run_cycles_q <= run_cycles_d;
         status_q     <= status_d;
         irq_q        <= irq_d;
      end
   end

   // reset_max and busy decode straight from the registered state.
   assign max_args.reset_max = (state_q != S_RUN);
   assign max_args.Ntau      = ntau_q;
   assign max_args.Nf        = nf_q;
   assign busy               = (state_q != S_IDLE);
   assign irq                = irq_q;
   assign status             = status_q;
   assign run_cycles         = run_cycles_q;

endmodule

// File: tb/tb_max_args_ctrl.sv
// Bench for max_args_ctrl: a table of directed searches, hand sequences for
// reset behaviour, and randomized searches checked against a search-level model.
module tb_max_args_ctrl;
   localparam int R = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] cfg_ntau = '0;
   logic [15:0] cfg_nf = '0;
   logic [31:0] cfg_timeout = '0;
   logic        busy, irq;
   logic [2:0]  status;
   logic [31:0] run_cycles;

   max_args_interface mif();

   max_args_ctrl #(.RESET_LEN(R), .CNT_W(32)) dut (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort),
      .cfg_ntau(cfg_ntau), .cfg_nf(cfg_nf), .cfg_timeout(cfg_timeout),
      .max_args(mif), .busy(busy), .irq(irq), .status(status),
      .run_cycles(run_cycles)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   logic [31:0] prev_rc = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // One search: start at a negedge, then cycle n (1-based after acceptance)
   // gets done_max if n==dn, abort if n==an, and an extra start if n==sn.
   task automatic run_search(input string name, input logic [15:0] nt, input logic [15:0] nf,
                             input logic [31:0] to, input int dn, input int an, input int sn,
                             input logic [2:0] exp_st, input logic [31:0] exp_rc, input int exp_end);
      int busy_n = 0, low_n = 0, irq_n = 0, irq_at = -1;
      @(negedge clk);
      start = 1'b1; cfg_ntau = nt; cfg_nf = nf; cfg_timeout = to;
      for (int n = 1; n <= exp_end + 3; n++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (!mif.reset_max) low_n++;
         if (irq) begin
            irq_n++;
            if (irq_at < 0) irq_at = n;
         end
         start = (n == sn);
         if (n == sn) begin
            cfg_ntau = ~nt; cfg_nf = ~nf; cfg_timeout = 32'd5;
         end
         mif.done_max = (n == dn);
         abort = (n == an);
      end
      start = 1'b0; abort = 1'b0; mif.done_max = 1'b0;
      chk({name, ".busy_cycles"}, busy_n, exp_end);
      chk({name, ".rmax_low"}, low_n, (exp_st == 3'b100) ? 0 : exp_rc);
      chk({name, ".irq_count"}, irq_n, 1);
      chk({name, ".irq_at"}, irq_at, exp_end + 1);
      chk({name, ".status"}, status, exp_st);
      chk({name, ".run_cycles"}, run_cycles, exp_rc);
      chk({name, ".ntau"}, mif.Ntau, nt);
      chk({name, ".nf"}, mif.Nf, nf);
      chk({name, ".rmax_idle"}, mif.reset_max, 1'b1);
   endtask

   // Search-level model: earliest terminating event wins, ties resolved
   // abort > done > timeout; done during the clear phase does not count.
   task automatic model(input logic [15:0] nt, input logic [15:0] nf, input logic [31:0] to,
                        input int dn, input int an,
                        output logic [2:0] st, output logic [31:0] rc, output int nend);
      int best;
      if (nt == 0 || nf == 0) begin
         st = 3'b100; rc = prev_rc; nend = 0;
      end else begin
         best = 1 << 30; st = 3'b000;
         if (to != 0) begin best = R + int'(to); st = 3'b010; end
         if (dn > R && dn <= best) begin best = dn; st = 3'b001; end
         if (an >= 1 && an <= best) begin best = an; st = 3'b000; end
         nend = best;
         rc = (best > R) ? 32'(best - R) : 32'd0;
      end
   endtask

   typedef struct {
      logic [15:0] nt, nf;
      logic [31:0] to;
      int          dn, an, sn;
      logic [2:0]  st;
      logic [31:0] rc;
      int          nend;
   } vec_t;

   vec_t vt[11];

   initial begin
      int irq_seen;
      logic [2:0]  m_st;
      logic [31:0] m_rc;
      int          m_end, dn, an, sn;
      logic [15:0] nt, nf;
      logic [31:0] to;

      vt[0]  = '{16'd3, 16'd2, 32'd0,  54, 0,  0,  3'b001, 32'd50, 54}; // done 50 cycles in
      vt[1]  = '{16'd5, 16'd7, 32'd20, 0,  0,  0,  3'b010, 32'd20, 24}; // timeout 20
      vt[2]  = '{16'd4, 16'd0, 32'd0,  0,  0,  0,  3'b100, 32'd20, 0 }; // nf=0
      vt[3]  = '{16'd2, 16'd2, 32'd0,  10, 10, 0,  3'b000, 32'd6,  10}; // abort with done
      vt[4]  = '{16'd1, 16'd1, 32'd0,  5,  0,  0,  3'b001, 32'd1,  5 }; // restart, done first cycle
      vt[5]  = '{16'd9, 16'd3, 32'd1,  0,  0,  0,  3'b010, 32'd1,  5 }; // timeout of 1
      vt[6]  = '{16'd6, 16'd6, 32'd3,  7,  0,  0,  3'b001, 32'd3,  7 }; // done beats timeout
      vt[7]  = '{16'd8, 16'd1, 32'd2,  2,  0,  0,  3'b010, 32'd2,  6 }; // done in clear ignored
      vt[8]  = '{16'd7, 16'd5, 32'd0,  0,  2,  0,  3'b000, 32'd0,  2 }; // abort in clear
      vt[9]  = '{16'd3, 16'd4, 32'd8,  0,  0,  6,  3'b010, 32'd8,  12}; // start in run ignored
      vt[10] = '{16'd0, 16'd9, 32'd0,  0,  0,  0,  3'b100, 32'd8,  0 }; // ntau=0

      mif.done_max = 1'b0;
      #1;
      chk("rst.reset_max", mif.reset_max, 1'b1);
      chk("rst.busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      irq_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (irq) irq_seen++;
      end
      chk("idle.reset_max", mif.reset_max, 1'b1);
      chk("idle.busy", busy, 1'b0);
      chk("idle.status", status, 3'b000);
      chk("idle.irq_seen", irq_seen, 0);
      chk("idle.run_cycles", run_cycles, 32'd0);
      chk("idle.ntau", mif.Ntau, 16'd0);

      for (int i = 0; i < 11; i++)
         run_search($sformatf("vec%0d", i), vt[i].nt, vt[i].nf, vt[i].to,
                    vt[i].dn, vt[i].an, vt[i].sn, vt[i].st, vt[i].rc, vt[i].nend);

      // Reset 10 cycles into RUN, with an ignored second start beforehand.
      @(negedge clk);
      start = 1'b1; cfg_ntau = 16'd3; cfg_nf = 16'd2; cfg_timeout = 32'd0;
      for (int n = 1; n <= R + 10; n++) begin
         @(negedge clk);
         start = (n == R + 2);
         if (n == R + 2) begin cfg_ntau = 16'd9; cfg_nf = 16'd9; end
      end
      start = 1'b0;
      chk("midrst.pre_busy", busy, 1'b1);
      chk("midrst.pre_rmax", mif.reset_max, 1'b0);
      chk("midrst.pre_ntau", mif.Ntau, 16'd3);
      chk("midrst.pre_nf", mif.Nf, 16'd2);
      chk("midrst.pre_rc", run_cycles, 32'd9);
      #2 resetn = 1'b0;
      #1;
      chk("midrst.rmax", mif.reset_max, 1'b1);
      chk("midrst.busy", busy, 1'b0);
      chk("midrst.irq", irq, 1'b0);
      chk("midrst.status", status, 3'b000);
      chk("midrst.rc", run_cycles, 32'd0);
      chk("midrst.ntau", mif.Ntau, 16'd0);
      chk("midrst.nf", mif.Nf, 16'd0);
      repeat (10) @(negedge clk);
      resetn = 1'b1;
      prev_rc = '0;

      // Randomized searches against the model.
      for (int k = 0; k < 30; k++) begin
         nt = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
         nf = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
         to = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 15));
         dn = int'($urandom_range(0, 25));
         an = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
         if (to == 0 && dn <= R && an == 0) dn = R + 1 + int'($urandom_range(0, 15));
         model(nt, nf, to, dn, an, m_st, m_rc, m_end);
         sn = (m_end > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, m_end)) : 0;
         run_search($sformatf("rnd%0d", k), nt, nf, to, dn, an, sn, m_st, m_rc, m_end);
         prev_rc = m_rc;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
